// File: rtl/sram_checker_pkg.sv
// Shared types for the SRAM write checker: FSM states and the 2-bit per-location write count.
package sram_checker_pkg;

   typedef enum logic [2:0] {
      S_CHK_IDLE,
      S_CHK_CLEAR,
      S_CHK_MONITOR,
      S_CHK_DRAIN,
      S_CHK_SCAN,
      S_CHK_DONE
   } chk_state_t;

   typedef logic [1:0] wcount_t;

   localparam wcount_t WCOUNT_SAT = 2'd3;

   function automatic wcount_t wcount_inc(input wcount_t c);
      return (c == WCOUNT_SAT) ? c : c + 2'd1;
   endfunction

endpackage

// File: rtl/sram_wcount_ram.sv
// Per-location write-count store: simple dual-port RAM, one write and one registered read port.
module sram_wcount_ram
   import sram_checker_pkg::*;
#(
   parameter int unsigned DEPTH = 115200,
   parameter int unsigned AW    = 17
) (
   input  logic          clock_50,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  wcount_t       wdata,
   input  logic [AW-1:0] raddr,
   output wcount_t       rdata
);

   wcount_t mem [DEPTH];

   always_ff @(posedge clock_50) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/sram_write_checker.sv
// Snoops SRAM write strobes, compares each write against a golden image, tracks per-location
// write counts over a region and scans that region for unwritten locations on Finish_i.
module sram_write_checker
   import sram_checker_pkg::*;
#(
   parameter int unsigned ADDR_W         = 18,
   parameter int unsigned DATA_W         = 16,
   parameter int unsigned REGION_LO      = 146944,
   parameter int unsigned REGION_HI      = 262143,
   parameter int unsigned CNT_W          = 32,
   parameter int unsigned MAX_MISMATCHES = 10
) (
   input  logic              Clock_50,
   input  logic              Reset,
   input  logic              Start_i,
   input  logic              Finish_i,
   input  logic              SRAM_we_n_i,
   input  logic [ADDR_W-1:0] SRAM_address_i,
   input  logic [DATA_W-1:0] SRAM_write_data_i,
   output logic [ADDR_W-1:0] Exp_address_o,
   input  logic [DATA_W-1:0] Exp_data_i,
   output logic              Busy_o,
   output logic              Done_o,
   output logic              Stop_o,
   output logic [CNT_W-1:0]  Mismatch_count_o,
   output logic [CNT_W-1:0]  Out_of_region_count_o,
   output logic [CNT_W-1:0]  Multi_write_count_o,
   output logic [CNT_W-1:0]  Unwritten_count_o,
   output logic              First_err_valid_o,
   output logic [ADDR_W-1:0] First_err_address_o,
   output logic [DATA_W-1:0] First_err_data_o,
   output logic [DATA_W-1:0] First_err_expected_o,
   output logic [ADDR_W-1:0] First_unwritten_o
);

   localparam int unsigned DEPTH  = REGION_HI - REGION_LO + 1;
   localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   chk_state_t state, state_nx;

   logic [RAM_AW-1:0] clr_idx;
   logic [RAM_AW:0]   scan_idx;
   logic              scan_rd_valid;
   logic [RAM_AW-1:0] scan_rd_idx;

   logic              s0_fire;
   logic              s0_in_region;
   logic [RAM_AW-1:0] s0_idx;

   logic              s1_valid;
   logic              s1_in_region;
   logic [RAM_AW-1:0] s1_idx;
   logic [ADDR_W-1:0] s1_addr;
   logic [DATA_W-1:0] s1_data;
   logic              s1_mismatch;
   wcount_t           s1_prior;
   wcount_t           s1_new;
   logic [CNT_W-1:0]  mism_nx;

   logic              fwd_hit;
   wcount_t           fwd_cnt;

   logic              ram_we;
   logic [RAM_AW-1:0] ram_waddr;
   wcount_t           ram_wdata;
   logic [RAM_AW-1:0] ram_raddr;
   wcount_t           ram_rdata;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   assign Exp_address_o = SRAM_address_i;

   always_comb begin
      s0_fire      = (state == S_CHK_MONITOR) && !SRAM_we_n_i;
      s0_in_region = (32'(SRAM_address_i) >= REGION_LO) && (32'(SRAM_address_i) <= REGION_HI);
      s0_idx       = RAM_AW'(32'(SRAM_address_i) - REGION_LO);
      // a same-location write one cycle earlier has not reached the RAM read yet
      s1_prior     = fwd_hit ? fwd_cnt : ram_rdata;
      s1_new       = wcount_inc(s1_prior);
      s1_mismatch  = s1_valid && (s1_data != Exp_data_i);
      mism_nx      = sat_inc(Mismatch_count_o);
   end

   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = s1_idx;
      ram_wdata = s1_new;
      if (state == S_CHK_CLEAR) begin
         ram_we    = 1'b1;
         ram_waddr = clr_idx;
         ram_wdata = '0;
      end else if (s1_valid && s1_in_region) begin
         ram_we = 1'b1;
      end
      ram_raddr = (state == S_CHK_SCAN) ? scan_idx[RAM_AW-1:0] : s0_idx;
   end

   sram_wcount_ram #(
      .DEPTH (DEPTH),
      .AW    (RAM_AW)
   ) u_wcount_ram (
      .clock_50 (Clock_50),
      .we       (ram_we),
      .waddr    (ram_waddr),
      .wdata    (ram_wdata),
      .raddr    (ram_raddr),
      .rdata    (ram_rdata)
   );

   always_comb begin
      state_nx = state;
      case (state)
         S_CHK_IDLE:    state_nx = S_CHK_IDLE;
         S_CHK_CLEAR:   if (clr_idx == RAM_AW'(DEPTH - 1)) state_nx = S_CHK_MONITOR;
         S_CHK_MONITOR: if (Finish_i) state_nx = S_CHK_DRAIN;
         S_CHK_DRAIN:   state_nx = S_CHK_SCAN;
         S_CHK_SCAN:    if (32'(scan_idx) == DEPTH) state_nx = S_CHK_DONE;
         S_CHK_DONE:    state_nx = S_CHK_DONE;
         default:       state_nx = S_CHK_IDLE;
      endcase
      if (Start_i) state_nx = S_CHK_CLEAR;
   end

   always_comb begin
      Busy_o = (state == S_CHK_CLEAR) || (state == S_CHK_DRAIN) || (state == S_CHK_SCAN);
      Done_o = (state == S_CHK_DONE);
   end

   always_ff @(posedge Clock_50) begin
      if (Reset) state <= S_CHK_IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge Clock_50) begin
      if (Reset || Start_i) begin
         clr_idx               <= '0;
         scan_idx              <= '0;
         scan_rd_valid         <= 1'b0;
         scan_rd_idx           <= '0;
         s1_valid              <= 1'b0;
         s1_in_region          <= 1'b0;
         s1_idx                <= '0;
         s1_addr               <= '0;
         s1_data               <= '0;
         fwd_hit               <= 1'b0;
         fwd_cnt               <= '0;
         Stop_o                <= 1'b0;
         Mismatch_count_o      <= '0;
         Out_of_region_count_o <= '0;
         Multi_write_count_o   <= '0;
         Unwritten_count_o     <= '0;
         First_err_valid_o     <= 1'b0;
         First_err_address_o   <= '0;
         First_err_data_o      <= '0;
         First_err_expected_o  <= '0;
         First_unwritten_o     <= '0;
      end else begin
         s1_valid <= s0_fire;
         if (s0_fire) begin
            s1_addr      <= SRAM_address_i;
            s1_data      <= SRAM_write_data_i;
            s1_in_region <= s0_in_region;
            s1_idx       <= s0_idx;
            fwd_hit      <= s1_valid && s1_in_region && s0_in_region && (s0_idx == s1_idx);
            fwd_cnt      <= s1_new;
         end

         if (state == S_CHK_CLEAR) clr_idx <= clr_idx + RAM_AW'(1);

         if (s1_valid) begin
            if (s1_mismatch) begin
               Mismatch_count_o <= mism_nx;
               if (mism_nx >= CNT_W'(MAX_MISMATCHES)) Stop_o <= 1'b1;
               if (!First_err_valid_o) begin
                  First_err_valid_o    <= 1'b1;
                  First_err_address_o  <= s1_addr;
                  First_err_data_o     <= s1_data;
                  First_err_expected_o <= Exp_data_i;
               end
            end
            if (s1_in_region) begin
               if (s1_prior != '0) Multi_write_count_o <= sat_inc(Multi_write_count_o);
            end else begin
               Out_of_region_count_o <= sat_inc(Out_of_region_count_o);
            end
         end

         if (state == S_CHK_DRAIN) begin
            scan_idx          <= '0;
            scan_rd_valid     <= 1'b0;
            Unwritten_count_o <= '0;
            First_unwritten_o <= '0;
         end

         // read issued in cycle k returns in cycle k+1, hence the extra scan cycle
         if (state == S_CHK_SCAN) begin
            scan_idx      <= scan_idx + (RAM_AW + 1)'(1);
            scan_rd_valid <= (32'(scan_idx) < DEPTH);
            scan_rd_idx   <= scan_idx[RAM_AW-1:0];
            if (scan_rd_valid && (ram_rdata == '0)) begin
               Unwritten_count_o <= sat_inc(Unwritten_count_o);
               if (Unwritten_count_o == '0)
                  First_unwritten_o <= ADDR_W'(REGION_LO + 32'(scan_rd_idx));
            end
         end
      end
   end

endmodule
